mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 16-bit MIPS pipeline; sits between EX and Back_Block.
//  Takes the EX result as address or pass-through value and performs a data-memory load or store.
//  Registers the stage result as ans_dm, plus the writeback tags.
//  Back_Block consumes ans_dm and registers it into ans_wb.
// PARAMETERS
//  DATA_W  16  data path / memory word width (bits)
//  ADDR_W  8   data memory address width; depth = 2**ADDR_W words
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       synchronous, active-low reset (0 = reset)
//  ans_ex        in   DATA_W  EX result: memory address for load/store, else pass-through value
//  store_data    in   DATA_W  word written on store
//  mem_read      in   1       load request this cycle
//  mem_write     in   1       store request this cycle
//  rd_ex         in   3       destination register tag from EX
//  reg_write_ex  in   1       writeback enable from EX
//  stall         in   1       hold stage: no memory write, outputs frozen
//  ans_dm        out  DATA_W  registered stage result, to Back_Block
//  rd_dm         out  3       registered destination tag
//  reg_write_dm  out  1       registered writeback enable
//  mem_err       out  1       sticky flag: mem_read and mem_write were both seen
// BEHAVIOUR
//  - All state updates on the rising clk edge. Reset is sampled only at the edge.
//  - Reset (reset==0 at edge): ans_dm=0, rd_dm=0, reg_write_dm=0, mem_err=0.
//    No memory write occurs that cycle. Memory contents are NOT cleared.
//  - Address = ans_ex[ADDR_W-1:0] (word addressed); upper bits are ignored, so the address wraps mod depth.
//  - Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
//  - When stall==1 (and reset==1):
//    - No memory write.
//    - All outputs hold their values; mem_err does not update.
//  - When stall==0, the cycle is decoded as:
//    - mem_write=1, mem_read=0: mem[addr] <= store_data; ans_dm <= ans_ex.
//    - mem_read=1, mem_write=0: ans_dm <= mem[addr]. This is the value before any write in the same edge; only one port is active per cycle.
//    - neither: ans_dm <= ans_ex (ALU pass-through).
//    - both=1 (illegal): the write is performed; ans_dm <= ans_ex; mem_err <= 1.
//  - rd_dm <= rd_ex and reg_write_dm <= reg_write_ex on every non-stalled cycle.
//  - mem_err stays 1 until reset.
//  - Store at edge N followed by a load of the same address at edge N+1: the load returns the new data. No bypass is needed.
//  - Reset has priority over stall. A store presented in a reset cycle is dropped.
//  - Memory is a single-port synchronous array, inferrable as block RAM.
// TESTING
//  1 Reset: hold reset=0 two edges with mem_write=1 at addr 5.
//    -> all outputs 0; a later load of addr 5 shows the old/unknown contents, not store_data.
//  2 Store/load: store 16'h00A3 @ addr 3.
//    -> next cycle load addr 3; ans_dm=16'h00A3 one edge after the load; Back_Block ans_wb=16'h00A3 one edge later.
//  3 Pass-through: ans_ex=16'h0023, rd_ex=3'd4, reg_write_ex=1, no mem op.
//    -> ans_dm=16'h0023, rd_dm=4, reg_write_dm=1 after 1 edge.
//  4 Wrap: store 16'h1234 with ans_ex=16'h0105 (ADDR_W=8).
//    -> load with ans_ex=16'h0005 returns 16'h1234.
//  5 Stall: ans_dm=16'h0011 latched; set stall=1 and present store 16'hBEEF @ addr 7 plus new ans_ex.
//    -> outputs hold 16'h0011; a later load of addr 7 does not return 16'hBEEF.
//  6 Illegal: mem_read=mem_write=1, ans_ex=9, store_data=16'h5555.
//    -> mem_err=1 and stays 1; ans_dm=9; a load of addr 9 returns 16'h5555; reset clears mem_err.

Source files
------------

// File: rtl/mem_stage_if.sv
// Bundle of signals exchanged between the EX side and the MEM stage.
// The slave modport is the stage's view; master is the driver's view.
interface mem_stage_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] ans_ex;
   logic [DATA_W-1:0] store_data;
   logic              mem_read;
   logic              mem_write;
   logic [2:0]        rd_ex;
   logic              reg_write_ex;
   logic              stall;
   logic [DATA_W-1:0] ans_dm;
   logic [2:0]        rd_dm;
   logic              reg_write_dm;
   logic              mem_err;

   modport slave (
      input  ans_ex, store_data, mem_read, mem_write, rd_ex, reg_write_ex, stall,
      output ans_dm, rd_dm, reg_write_dm, mem_err
   );

   modport master (
      output ans_ex, store_data, mem_read, mem_write, rd_ex, reg_write_ex, stall,
      input  ans_dm, rd_dm, reg_write_dm, mem_err
   );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage of the 16-bit pipeline: one-cycle data-memory load/store or
// ALU pass-through, registering the result and writeback tags for Back_Block.
module mem_access_stage #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic       clk_i,
   input  logic       reset_i,
   mem_stage_if.slave bus
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   logic [DATA_W-1:0] passVal_q, passVal_d;
   logic              selRead_q, selRead_d;
   logic [2:0]        rd_q, rd_d;
   logic              regWrite_q, regWrite_d;
   logic              memErr_q, memErr_d;

   logic [ADDR_W-1:0] addr;
   logic              active;
   logic              writeEn;

   assign addr    = bus.ans_ex[ADDR_W-1:0];
   assign active  = reset_i && !bus.stall;
   assign writeEn = active && bus.mem_write;

   // Plain synchronous write/read ports with no reset so the array maps onto block RAM.
   always_ff @(posedge clk_i) begin
      if (writeEn) begin
         mem_q[addr] <= bus.store_data;
      end
   end

   always_ff @(posedge clk_i) begin
      if (active) begin
         rdata_q <= mem_q[addr];
      end
   end

   always_comb begin
      passVal_d  = passVal_q;
      selRead_d  = selRead_q;
      rd_d       = rd_q;
      regWrite_d = regWrite_q;
      memErr_d   = memErr_q;
      if (!bus.stall) begin
         passVal_d  = bus.ans_ex;
         selRead_d  = bus.mem_read && !bus.mem_write;
         rd_d       = bus.rd_ex;
         regWrite_d = bus.reg_write_ex;
         if (bus.mem_read && bus.mem_write) begin
            memErr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         passVal_q  <= '0;
         selRead_q  <= 1'b0;
         rd_q       <= '0;
         regWrite_q <= 1'b0;
         memErr_q   <= 1'b0;
      end else begin
         passVal_q  <= passVal_d;
         selRead_q  <= selRead_d;
         rd_q       <= rd_d;
         regWrite_q <= regWrite_d;
         memErr_q   <= memErr_d;
      end
   end

   // A load's result comes straight from the RAM output register; everything else is the latched EX value.
   assign bus.ans_dm       = selRead_q ? rdata_q : passVal_q;
   assign bus.rd_dm        = rd_q;
   assign bus.reg_write_dm = regWrite_q;
   assign bus.mem_err      = memErr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: hand-computed vectors checked with
// immediate assertions, plus a register standing in for Back_Block's ans_wb.
module tb_mem_access_stage;

   logic clk;
   logic reset;
   int   compareCount;
   int   failCount;
   logic [15:0] ansWb;

   mem_stage_if #(.DATA_W(16)) bus ();

   mem_access_stage #(.DATA_W(16), .ADDR_W(8)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Back_Block registers the stage result one edge later.
   always_ff @(posedge clk) begin
      if (!reset) ansWb <= '0;
      else        ansWb <= bus.ans_dm;
   end

   // Drive one cycle's inputs, clock one edge, and settle past it.
   task automatic applyStimulus(input logic rst, input logic stl, input logic rd,
                                input logic wr, input logic [15:0] ansEx,
                                input logic [15:0] sd, input logic [2:0] rdEx,
                                input logic regWr);
      reset               = rst;
      bus.stall           = stl;
      bus.mem_read        = rd;
      bus.mem_write       = wr;
      bus.ans_ex          = ansEx;
      bus.store_data      = sd;
      bus.rd_ex           = rdEx;
      bus.reg_write_ex    = regWr;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compareCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      compareCount = 0;
      failCount    = 0;
      reset = 1'b0;
      bus.stall = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      bus.ans_ex = '0; bus.store_data = '0; bus.rd_ex = '0; bus.reg_write_ex = 1'b0;

      // Reset state
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0);
      checkOutput("rst_ans_dm",  bus.ans_dm, 16'h0000);
      checkOutput("rst_rd_dm",   {13'b0, bus.rd_dm}, 16'h0000);
      checkOutput("rst_regwr",   {15'b0, bus.reg_write_dm}, 16'h0000);
      checkOutput("rst_mem_err", {15'b0, bus.mem_err}, 16'h0000);

      // Known value at addr 5, then two reset edges carrying a store that must be dropped
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h0101, 3'd2, 1'b1);
      checkOutput("store5_ans_dm", bus.ans_dm, 16'h0005);
      checkOutput("store5_rd_dm",  {13'b0, bus.rd_dm}, 16'h0002);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 16'hDEAD, 3'd7, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 16'hDEAD, 3'd7, 1'b1);
      checkOutput("rst2_ans_dm", bus.ans_dm, 16'h0000);
      checkOutput("rst2_rd_dm",  {13'b0, bus.rd_dm}, 16'h0000);
      checkOutput("rst2_regwr",  {15'b0, bus.reg_write_dm}, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 3'd1, 1'b1);
      checkOutput("load5_after_rst", bus.ans_dm, 16'h0101);

      // Store then load at addr 3, followed by Back_Block capture
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h0003, 16'h00A3, 3'd0, 1'b0);
      checkOutput("store3_ans_dm", bus.ans_dm, 16'h0003);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 3'd1, 1'b1);
      checkOutput("load3_ans_dm", bus.ans_dm, 16'h00A3);
      checkOutput("load3_rd_dm",  {13'b0, bus.rd_dm}, 16'h0001);

      // Pass-through; Back_Block now holds the previous load result
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0023, 16'h0000, 3'd4, 1'b1);
      checkOutput("pass_ans_dm", bus.ans_dm, 16'h0023);
      checkOutput("pass_rd_dm",  {13'b0, bus.rd_dm}, 16'h0004);
      checkOutput("pass_regwr",  {15'b0, bus.reg_write_dm}, 16'h0001);
      checkOutput("wb_ans_wb",   ansWb, 16'h00A3);

      // Address wraps modulo depth
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h0105, 16'h1234, 3'd0, 1'b0);
      checkOutput("wrap_store_ans_dm", bus.ans_dm, 16'h0105);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 3'd0, 1'b0);
      checkOutput("wrap_load_ans_dm", bus.ans_dm, 16'h1234);

      // Stall holds outputs and suppresses the store and the error flag
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h0007, 16'h4444, 3'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, 3'd3, 1'b0);
      checkOutput("prestall_ans_dm", bus.ans_dm, 16'h0011);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0007, 16'hBEEF, 3'd6, 1'b1);
      checkOutput("stall_ans_dm", bus.ans_dm, 16'h0011);
      checkOutput("stall_rd_dm",  {13'b0, bus.rd_dm}, 16'h0003);
      checkOutput("stall_regwr",  {15'b0, bus.reg_write_dm}, 16'h0000);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h0007, 16'hBEEF, 3'd6, 1'b1);
      checkOutput("stall_both_ans_dm",  bus.ans_dm, 16'h0011);
      checkOutput("stall_both_mem_err", {15'b0, bus.mem_err}, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0007, 16'h0000, 3'd0, 1'b0);
      checkOutput("load7_after_stall", bus.ans_dm, 16'h4444);

      // Illegal read+write: store happens, pass-through result, sticky error
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h0009, 16'h5555, 3'd5, 1'b1);
      checkOutput("illegal_ans_dm",  bus.ans_dm, 16'h0009);
      checkOutput("illegal_mem_err", {15'b0, bus.mem_err}, 16'h0001);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0009, 16'h0000, 3'd0, 1'b0);
      checkOutput("load9_ans_dm",  bus.ans_dm, 16'h5555);
      checkOutput("load9_mem_err", {15'b0, bus.mem_err}, 16'h0001);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0);
      checkOutput("sticky_mem_err", {15'b0, bus.mem_err}, 16'h0001);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0);
      checkOutput("rst_clears_mem_err", {15'b0, bus.mem_err}, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
